// File: rtl/enemy_movement_controller.sv
// enemy_movement_controller
// Random-walk controller for one enemy sprite. A random nibble is sampled at
// each decision point: rand[1:0] picks the facing, rand[3:2]==00 selects a
// pause, anything else a walk. Walks and pauses last MOVE_TICKS frame ticks;
// a walk that would leave the playfield stops early and re-decides. A hit
// freezes the enemy for STUN_TICKS frame ticks.
module enemy_movement_controller #(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 304,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 224,
    parameter int SPAWN_X    = 152,
    parameter int SPAWN_Y    = 112,
    parameter int MOVE_TICKS = 16,
    parameter int STUN_TICKS = 32
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       frame_tick_i,
    input  logic [3:0] rand_i,
    input  logic       hit_i,
    output logic [8:0] x_pos_o,
    output logic [7:0] y_pos_o,
    output logic [1:0] direction_o,
    output logic       moving_o,
    output logic       stunned_o,
    output logic       decide_strobe_o
);

    // Elaboration-time guard against parameter values the datapath cannot hold
    generate
        if (MOVE_TICKS < 1 || MOVE_TICKS > 63) begin : g_bad_move_ticks
            $error("enemy_movement_controller: MOVE_TICKS must be 1..63");
        end
        if (STUN_TICKS < 1 || STUN_TICKS > 63) begin : g_bad_stun_ticks
            $error("enemy_movement_controller: STUN_TICKS must be 1..63");
        end
        if (X_MIN < 0 || X_MAX > 511 || X_MIN > X_MAX) begin : g_bad_x_range
            $error("enemy_movement_controller: x bounds must fit 9 bits with X_MIN <= X_MAX");
        end
        if (Y_MIN < 0 || Y_MAX > 255 || Y_MIN > Y_MAX) begin : g_bad_y_range
            $error("enemy_movement_controller: y bounds must fit 8 bits with Y_MIN <= Y_MAX");
        end
        if (SPAWN_X < X_MIN || SPAWN_X > X_MAX || SPAWN_Y < Y_MIN || SPAWN_Y > Y_MAX) begin : g_bad_spawn
            $error("enemy_movement_controller: spawn point must lie inside the playfield");
        end
    endgenerate

    localparam logic [8:0] X_MIN_C   = 9'(X_MIN);
    localparam logic [8:0] X_MAX_C   = 9'(X_MAX);
    localparam logic [7:0] Y_MIN_C   = 8'(Y_MIN);
    localparam logic [7:0] Y_MAX_C   = 8'(Y_MAX);
    localparam logic [8:0] SPAWN_X_C = 9'(SPAWN_X);
    localparam logic [7:0] SPAWN_Y_C = 8'(SPAWN_Y);
    localparam logic [5:0] MOVE_T_C  = 6'(MOVE_TICKS);
    localparam logic [5:0] STUN_T_C  = 6'(STUN_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_MOVE,
        S_PAUSE,
        S_STUN
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [5:0] cnt_q, cnt_d;

    logic       disable_req;
    logic       hit_take;
    logic       step_blocked;
    logic [5:0] cnt_inc;
    logic       move_done;
    logic       stun_done;

    // Event decode shared by the state and datapath logic
    always_comb begin
        // Dropping enable outranks every other event in any active state
        disable_req = (state_q != S_IDLE) && !enable_i;
        hit_take    = hit_i && (state_q != S_IDLE);
        cnt_inc     = cnt_q + 6'd1;
        move_done   = (cnt_inc == MOVE_T_C);
        stun_done   = (cnt_inc == STUN_T_C);
        // Compare before stepping so the unsigned position can never wrap
        step_blocked = 1'b0;
        case (dir_q)
            DIR_UP:    step_blocked = (y_q <= Y_MIN_C);
            DIR_DOWN:  step_blocked = (y_q >= Y_MAX_C);
            DIR_LEFT:  step_blocked = (x_q <= X_MIN_C);
            DIR_RIGHT: step_blocked = (x_q >= X_MAX_C);
            default:   step_blocked = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable drop > hit > boundary block > tick count
    always_comb begin
        state_d = state_q;
        if (disable_req) begin
            state_d = S_IDLE;
        end else if (hit_take) begin
            state_d = S_STUN;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_d = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    state_d = (rand_i[3:2] == 2'b00) ? S_PAUSE : S_MOVE;
                end
                S_MOVE: begin
                    if (frame_tick_i && (step_blocked || move_done)) begin
                        state_d = S_DECIDE;
                    end
                end
                S_PAUSE: begin
                    if (frame_tick_i && move_done) begin
                        state_d = S_DECIDE;
                    end
                end
                S_STUN: begin
                    if (frame_tick_i && stun_done) begin
                        state_d = S_DECIDE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: facing latch, tick counter and position step
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        cnt_d = cnt_q;
        if (!disable_req) begin
            // Facing is latched in DECIDE even when a hit arrives the same cycle
            if (state_q == S_DECIDE) begin
                dir_d = dir_e'(rand_i[1:0]);
                cnt_d = '0;
            end
            if (hit_take) begin
                cnt_d = '0;
            end else if (frame_tick_i) begin
                case (state_q)
                    S_MOVE: begin
                        if (!step_blocked) begin
                            cnt_d = cnt_inc;
                            case (dir_q)
                                DIR_UP:    y_d = y_q - 8'd1;
                                DIR_DOWN:  y_d = y_q + 8'd1;
                                DIR_LEFT:  x_d = x_q - 9'd1;
                                DIR_RIGHT: x_d = x_q + 9'd1;
                                default:   x_d = x_q;
                            endcase
                        end
                    end
                    S_PAUSE, S_STUN: begin
                        cnt_d = cnt_inc;
                    end
                    default: cnt_d = cnt_q;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            x_q   <= SPAWN_X_C;
            y_q   <= SPAWN_Y_C;
            dir_q <= DIR_UP;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dir_q <= dir_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs: registered position/facing and pure decodes of the state register
    always_comb begin
        x_pos_o         = x_q;
        y_pos_o         = y_q;
        direction_o     = dir_q;
        moving_o        = (state_q == S_MOVE);
        stunned_o       = (state_q == S_STUN);
        decide_strobe_o = (state_q == S_DECIDE);
    end

endmodule
